load_store_unit: RTL and testbench

Multi-cycle load/store unit placed directly downstream of the ALU in the single-cycle RISC-V core. It takes the ALU result as the effective address and drives a word-wide request/grant/response data bus. It generates byte enables and store-data lane replication, and sign- or zero-extends load data. It stalls the core until the access completes, is found misaligned, or times out.

---
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RISC-V load/store unit driving a req/gnt/rvalid word bus.
// Define LSU_TIMEOUT_EN to abort accesses that spend TIMEOUT cycles in REQ+WAIT.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_valid,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_timeout,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic [1:0] addr_lo, size_q;
  logic uns_q, to_hit, mis;
  logic [3:0] be;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [31:0] wdata, ext;
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end
  assign stall = !rst && ((state == IDLE && mem_op_valid) || state == REQ || state == WAIT);
  always_comb begin
    mis = (size == 2'b11) || (size == 2'b10 && alu_out[1:0] != 2'b00) || (size == 2'b01 && alu_out[0]);
    be = size == 2'b00 ? 4'b0001 << alu_out[1:0] : size == 2'b01 ? 4'b0011 << {alu_out[1], 1'b0} : 4'b1111;
    wdata = size == 2'b00 ? {4{store_data[7:0]}} : size == 2'b01 ? {2{store_data[15:0]}} : store_data;
    byte_v = 8'(bus_rdata >> {addr_lo, 3'b000});
    half_v = 16'(bus_rdata >> {addr_lo[1], 4'b0000});
    ext = size_q == 2'b00 ? {{24{!uns_q && byte_v[7]}}, byte_v} :
          size_q == 2'b01 ? {{16{!uns_q && half_v[15]}}, half_v} : bus_rdata;
  end
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  // Held at zero in IDLE, so it is already clear on the first REQ cycle.
  always_ff @(posedge clk)
    if (rst || state == IDLE) cnt <= '0;
    else if (state != DONE) cnt <= cnt + 1'b1;
  assign to_hit = cnt == CW'(TIMEOUT - 1);
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
      done <= 1'b0;
      misaligned <= 1'b0;
      bus_timeout <= 1'b0;
      load_data <= '0;
      addr_lo <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_op_valid) begin
          addr_lo <= alu_out[1:0];
          size_q <= size;
          uns_q <= is_unsigned;
          bus_we <= is_store;
          bus_addr <= {alu_out[31:2], 2'b00};
          bus_be <= be;
          bus_wdata <= wdata;
          load_data <= '0;
          state <= mis ? DONE : REQ;
          bus_req <= !mis;
          done <= mis;
          misaligned <= mis;
        end
        // bus_we doubles as the latched store flag; a grant beats a same-cycle timeout.
        REQ: if (bus_gnt || to_hit) begin
          bus_req <= 1'b0;
          state <= (bus_gnt && !bus_we) ? WAIT : DONE;
          done <= bus_gnt ? bus_we : 1'b1;
          bus_timeout <= !bus_gnt;
        end
        WAIT: if (bus_rvalid || to_hit) begin
          state <= DONE;
          done <= 1'b1;
          bus_timeout <= !bus_rvalid;
          load_data <= bus_rvalid ? ext : '0;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          misaligned <= 1'b0;
          bus_timeout <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized transactions checked cycle by cycle against a behavioural model.
module tb_load_store_unit;
  localparam int TO = 6;
`ifdef LSU_TIMEOUT_EN
  localparam int LIM = TO - 1;
`else
  localparam int LIM = 1 << 20;
`endif
  logic clk = 0, rst = 1, mem_op_valid = 0, is_store = 0, is_unsigned = 0, bus_gnt = 0, bus_rvalid = 0;
  logic [1:0] size = 0;
  logic [31:0] alu_out = 0, store_data = 0, bus_rdata = 0;
  logic stall, done, misaligned, bus_timeout, bus_req, bus_we;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  int checks = 0, fails = 0;
  logic chk_en = 0;
  logic e_stall, e_req, e_done, e_we, e_mis, e_to;
  logic [31:0] e_addr, e_wd, e_ld;
  logic [3:0] e_be;
  logic [31:0] seen_ld, seen_wd;
  logic [3:0] seen_be;
  logic seen_mis;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_op_valid(mem_op_valid), .is_store(is_store), .size(size),
    .is_unsigned(is_unsigned), .alu_out(alu_out), .store_data(store_data), .stall(stall),
    .done(done), .load_data(load_data), .misaligned(misaligned), .bus_timeout(bus_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_n(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
    return sz == 2'd3 || (int'(a[1:0]) % m_n(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = i >= int'(a[1:0]) && i < int'(a[1:0]) + m_n(sz);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] sd, input logic [1:0] sz);
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % m_n(sz)) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [31:0] rd,
                                         input logic [1:0] sz, input logic uns);
    int n, off;
    longint v;
    n = m_n(sz);
    off = int'(a[1:0]);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(rd[8*(off+i) +: 8]) << (8*i);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return 32'(v);
  endfunction

  always @(negedge clk) if (chk_en) begin
    check("stall", 32'(stall), 32'(e_stall));
    check("bus_req", 32'(bus_req), 32'(e_req));
    check("done", 32'(done), 32'(e_done));
    if (e_req) begin
      check("bus_we", 32'(bus_we), 32'(e_we));
      check("bus_addr", bus_addr, e_addr);
      check("bus_be", 32'(bus_be), 32'(e_be));
      check("bus_wdata", bus_wdata, e_wd);
      seen_be = bus_be;
      seen_wd = bus_wdata;
    end
    if (e_done) begin
      check("misaligned", 32'(misaligned), 32'(e_mis));
      check("bus_timeout", 32'(bus_timeout), 32'(e_to));
      check("load_data", load_data, e_ld);
      seen_ld = load_data;
      seen_mis = misaligned;
    end
  end

  // g: cycles of REQ before gnt, r: cycles from gnt to rvalid, rst_at: cycle of an aborting reset
  task automatic run(input logic st, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd, input int g, input int r,
                     input int rst_at = -1);
    logic mis, to;
    int ck, d, rq_last, last;
    mis = m_mis(a, sz);
    ck = st ? g : g + r;
    d = mis ? 1 : 2 + (ck < LIM ? ck : LIM);
    to = !mis && ck > LIM;
    rq_last = mis ? 0 : 1 + (g < LIM ? g : LIM);
    last = rst_at >= 0 ? rst_at + 3 : d;
    e_we = st;
    e_addr = {a[31:2], 2'b00};
    e_be = m_be(a, sz);
    e_wd = m_wd(sd, sz);
    e_mis = mis;
    e_to = to;
    e_ld = (st || mis || to) ? 32'd0 : m_load(a, rd, sz, uns);
    for (int c = 0; c <= last; c++) begin
      logic ab;
      ab = rst_at >= 0 && c > rst_at;
      rst = c == rst_at;
      mem_op_valid = c == 0 || (c == d && rst_at < 0 && $urandom_range(1) == 1);
      is_store = c == 0 ? st : 1'($urandom);
      size = c == 0 ? sz : 2'($urandom);
      is_unsigned = c == 0 ? uns : 1'($urandom);
      alu_out = c == 0 ? a : $urandom;
      store_data = c == 0 ? sd : $urandom;
      bus_gnt = c == 1 + g || (rst_at < 0 && (c == 0 || c > rq_last) && $urandom_range(1) == 1);
      bus_rvalid = (!st && c == 1 + g + r) || (rst_at < 0 && (c < 1 + g || c >= d) && $urandom_range(1) == 1);
      bus_rdata = (!st && c == 1 + g + r) ? rd : $urandom;
      e_stall = !ab && c != rst_at && c < d;
      e_req = !ab && c >= 1 && c <= rq_last;
      e_done = !ab && c == d && (rst_at < 0 || d <= rst_at);
      chk_en = 1;
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  task automatic idle();
    mem_op_valid = 0;
    bus_gnt = 1'($urandom);
    bus_rvalid = 1'($urandom);
    e_stall = 0;
    e_req = 0;
    e_done = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic st, uns;
    logic [1:0] sz;
    logic [31:0] a;
    rst = 1;
    mem_op_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_req", 32'(bus_req), 0);
    check("rst_we", 32'(bus_we), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mis", 32'(misaligned), 0);
    check("rst_to", 32'(bus_timeout), 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", 32'(bus_be), 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_ld", load_data, 0);
    @(posedge clk); #1;
    rst = 0;
    mem_op_valid = 0;
    run(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 0, 1);
    check("sw_be", 32'(seen_be), 32'hF);
    check("sw_wdata", seen_wd, 32'hDEADBEEF);
    run(0, 2'd0, 0, 32'h103, 0, 32'h80112233, 0, 1);
    check("lb_be", 32'(seen_be), 32'h8);
    check("lb_data", seen_ld, 32'hFFFFFF80);
    run(0, 2'd0, 1, 32'h103, 0, 32'h80112233, 0, 1);
    check("lbu_data", seen_ld, 32'h00000080);
    run(1, 2'd1, 0, 32'h102, 32'h1234ABCD, 0, 0, 1);
    check("sh_be", 32'(seen_be), 32'hC);
    check("sh_wdata", seen_wd, 32'hABCDABCD);
    run(0, 2'd1, 0, 32'h102, 0, 32'h8001FFFF, 2, 3);
    check("lh_data", seen_ld, 32'hFFFF8001);
    run(0, 2'd2, 0, 32'h102, 0, 32'h12345678, 0, 1);
    check("lw_mis", 32'(seen_mis), 1);
    check("lw_mis_data", seen_ld, 0);
    run(1, 2'd2, 0, 32'h100, 32'h1, 0, TO + 3, 1);
    run(0, 2'd2, 0, 32'h104, 0, 32'hCAFEF00D, TO, 2);
    run(0, 2'd2, 0, 32'h200, 0, 32'h55AA55AA, 0, 2, 2);
    run(0, 2'd2, 0, 32'h204, 0, 32'h0BADBEEF, 1, 1);
    repeat (300) begin
      st = 1'($urandom);
      uns = 1'($urandom);
      sz = $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom_range(1) == 1) a[1:0] = sz == 2'd2 ? 2'b00 : sz == 2'd1 ? {a[1], 1'b0} : a[1:0];
      run(st, sz, uns, a, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(1, 4));
      if ($urandom_range(3) == 0) idle();
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
